// File: rtl/pipeline_sequencer_if.sv
// Pipeline sequencer bus: decode/execute/memory hazard inputs and the
// bypass, stall, flush and mul/div control outputs of the sequencer.
interface pipeline_sequencer_if;
    logic [4:0]  decRs1;
    logic [4:0]  decRs2;
    logic        decRs1Used;
    logic        decRs2Used;
    logic        decValid;
    logic        decIsMulDiv;
    logic [4:0]  exRd;
    logic        exWrEn;
    logic        exIsLoad;
    logic [4:0]  memRd;
    logic        memWrEn;
    logic        exBrMiss;
    logic        mdDone;
    logic [1:0]  op1BypassCtrl;
    logic [1:0]  op2BypassCtrl;
    logic        stallFetch;
    logic        stallDecode;
    logic        flushExecute;
    logic        flushDecode;
    logic        isBranchPredictMiss;
    logic        mdStart;
    logic        mdAbort;
    logic        mdTimeout;
    logic [15:0] stallCount;

    // Pipeline side: drives stage information, consumes control.
    modport master (
        output decRs1, decRs2, decRs1Used, decRs2Used, decValid, decIsMulDiv,
        output exRd, exWrEn, exIsLoad, memRd, memWrEn, exBrMiss, mdDone,
        input  op1BypassCtrl, op2BypassCtrl, stallFetch, stallDecode,
        input  flushExecute, flushDecode, isBranchPredictMiss,
        input  mdStart, mdAbort, mdTimeout, stallCount
    );

    // Sequencer side.
    modport slave (
        input  decRs1, decRs2, decRs1Used, decRs2Used, decValid, decIsMulDiv,
        input  exRd, exWrEn, exIsLoad, memRd, memWrEn, exBrMiss, mdDone,
        output op1BypassCtrl, op2BypassCtrl, stallFetch, stallDecode,
        output flushExecute, flushDecode, isBranchPredictMiss,
        output mdStart, mdAbort, mdTimeout, stallCount
    );
endinterface

// File: rtl/pipeline_sequencer.sv
// Pipeline sequencer: operand bypass selection, load-use stall, branch
// mispredict flush and a RUN/MD_WAIT FSM that holds the pipe while a
// multi-cycle mul/div unit works, aborting it on mispredict or timeout.
module pipeline_sequencer (
    input  logic                  clk,
    input  logic                  rst,
    pipeline_sequencer_if.slave   seqIf
);
    typedef enum logic [0:0] {RUN, MD_WAIT} stateT;

    stateT       state;
    stateT       stateNext;
    logic [5:0]  waitCnt;
    logic        loadUseHazard;
    logic        timeoutHit;
    logic        stallFetch;
    logic        stallDecode;
    logic        flushExecute;
    logic        flushDecode;
    logic        mdStart;
    logic        mdAbort;
    logic        mdTimeout;
    logic [15:0] stallCount;
    logic [1:0]  op1Sel;
    logic [1:0]  op2Sel;

    // EX/MEM result wins over MEM/WB; register 0 is never forwarded.
    function automatic logic [1:0] bypassSel(
        input logic [4:0] rs,
        input logic       used,
        input logic [4:0] exRd,
        input logic       exWrEn,
        input logic [4:0] memRd,
        input logic       memWrEn
    );
        if (used && exWrEn && exRd != 5'd0 && exRd == rs)
            return 2'd1;
        else if (used && memWrEn && memRd != 5'd0 && memRd == rs)
            return 2'd2;
        else
            return 2'd0;
    endfunction

    // Saturating increment so the stall counter pins at all-ones.
    function automatic logic [15:0] satInc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Forwarding selects are pure decode of the current stage registers.
    always_comb begin
        op1Sel = bypassSel(seqIf.decRs1, seqIf.decRs1Used, seqIf.exRd,
                           seqIf.exWrEn, seqIf.memRd, seqIf.memWrEn);
        op2Sel = bypassSel(seqIf.decRs2, seqIf.decRs2Used, seqIf.exRd,
                           seqIf.exWrEn, seqIf.memRd, seqIf.memWrEn);
    end

    // Load in EX whose result a used decode source needs next cycle.
    always_comb begin
        loadUseHazard = seqIf.exIsLoad && seqIf.exWrEn && seqIf.exRd != 5'd0 &&
                        ((seqIf.decRs1Used && seqIf.exRd == seqIf.decRs1) ||
                         (seqIf.decRs2Used && seqIf.exRd == seqIf.decRs2));
    end

    // Next state and control outputs; mispredict overrides everything,
    // and all control is held quiet while reset is asserted.
    always_comb begin
        stateNext    = state;
        stallFetch   = 1'b0;
        stallDecode  = 1'b0;
        flushExecute = 1'b0;
        flushDecode  = 1'b0;
        mdStart      = 1'b0;
        mdAbort      = 1'b0;
        timeoutHit   = 1'b0;
        if (!rst) begin
            stateNext = RUN;
        end else if (seqIf.exBrMiss) begin
            flushDecode  = 1'b1;
            flushExecute = 1'b1;
            mdAbort      = (state == MD_WAIT);
            stateNext    = RUN;
        end else begin
            unique case (state)
                RUN: begin
                    if (loadUseHazard) begin
                        stallFetch   = 1'b1;
                        stallDecode  = 1'b1;
                        flushExecute = 1'b1;
                    end else if (seqIf.decValid && seqIf.decIsMulDiv) begin
                        mdStart   = 1'b1;
                        stateNext = MD_WAIT;
                    end
                end
                MD_WAIT: begin
                    if (seqIf.mdDone) begin
                        stateNext = RUN;
                    end else begin
                        stallFetch   = 1'b1;
                        stallDecode  = 1'b1;
                        flushExecute = 1'b1;
                        if (waitCnt == 6'd63) begin
                            mdAbort    = 1'b1;
                            timeoutHit = 1'b1;
                            stateNext  = RUN;
                        end
                    end
                end
                default: stateNext = RUN;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= RUN;
        else      state <= stateNext;
    end

    // Wait counter restarts on each mul/div issue and counts MD_WAIT cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                   waitCnt <= 6'd0;
        else if (state == RUN && stateNext == MD_WAIT) waitCnt <= 6'd0;
        else if (state == MD_WAIT)                  waitCnt <= waitCnt + 6'd1;
    end

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)            mdTimeout <= 1'b0;
        else if (timeoutHit) mdTimeout <= 1'b1;
    end

    // Count decode-stalled cycles, pinned at the maximum.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)             stallCount <= 16'd0;
        else if (stallDecode) stallCount <= satInc(stallCount);
    end

    assign seqIf.op1BypassCtrl       = op1Sel;
    assign seqIf.op2BypassCtrl       = op2Sel;
    assign seqIf.stallFetch          = stallFetch;
    assign seqIf.stallDecode         = stallDecode;
    assign seqIf.flushExecute        = flushExecute;
    assign seqIf.flushDecode         = flushDecode;
    assign seqIf.isBranchPredictMiss = seqIf.exBrMiss;
    assign seqIf.mdStart             = mdStart;
    assign seqIf.mdAbort             = mdAbort;
    assign seqIf.mdTimeout           = mdTimeout;
    assign seqIf.stallCount          = stallCount;
endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed bench for pipeline_sequencer with a scoreboard queue.
module tb_pipeline_sequencer;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pipeline_sequencer_if seqIf();

    pipeline_sequencer dut (
        .clk   (clk),
        .rst   (rst),
        .seqIf (seqIf)
    );

    typedef struct {
        string       tag;
        logic [15:0] val;
    } expT;

    expT sb[$];
    int  vectors     = 0;
    int  miscompares = 0;
    int  expStall    = 0;

    task automatic push(input string tag, input logic [15:0] val);
        expT e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic pop(input logic [15:0] obs);
        expT e;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL scoreboard: observed %0h with nothing expected", obs);
            return;
        end
        e = sb.pop_front();
        assert (obs === e.val) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
        end
    endtask

    // {stallFetch, stallDecode, flushExecute, flushDecode, mdStart, mdAbort}
    function automatic logic [15:0] ctrlObs();
        return {10'd0, seqIf.stallFetch, seqIf.stallDecode, seqIf.flushExecute,
                seqIf.flushDecode, seqIf.mdStart, seqIf.mdAbort};
    endfunction

    task automatic clearInputs();
        seqIf.decRs1 = 5'd0;  seqIf.decRs2 = 5'd0;
        seqIf.decRs1Used = 1'b0; seqIf.decRs2Used = 1'b0;
        seqIf.decValid = 1'b0; seqIf.decIsMulDiv = 1'b0;
        seqIf.exRd = 5'd0; seqIf.exWrEn = 1'b0; seqIf.exIsLoad = 1'b0;
        seqIf.memRd = 5'd0; seqIf.memWrEn = 1'b0;
        seqIf.exBrMiss = 1'b0; seqIf.mdDone = 1'b0;
    endtask

    function automatic int satNext(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    // Inputs are already driven (at the falling edge); check this cycle's
    // control and the stall count accumulated so far, then advance.
    task automatic cycle(input string tag, input logic [5:0] ctrl);
        push({tag, "-cnt"}, expStall[15:0]);
        push({tag, "-ctrl"}, {10'd0, ctrl});
        #1;
        pop(seqIf.stallCount);
        pop(ctrlObs());
        if (ctrl[4]) expStall = satNext(expStall);
        @(negedge clk);
    endtask

    task automatic checkBypass(input string tag, input logic [1:0] e1, input logic [1:0] e2);
        push({tag, "-op1"}, {14'd0, e1});
        push({tag, "-op2"}, {14'd0, e2});
        #1;
        pop({14'd0, seqIf.op1BypassCtrl});
        pop({14'd0, seqIf.op2BypassCtrl});
    endtask

    localparam logic [5:0] C_IDLE  = 6'b000000;
    localparam logic [5:0] C_STALL = 6'b111000;
    localparam logic [5:0] C_START = 6'b000010;
    localparam logic [5:0] C_TOUT  = 6'b111001;
    localparam logic [5:0] C_BR    = 6'b001100;
    localparam logic [5:0] C_BRAB  = 6'b001101;

    initial begin
        clearInputs();
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        push("rst-ctrl", 16'd0);
        push("rst-cnt", 16'd0);
        push("rst-tout", 16'd0);
        #1;
        pop(ctrlObs());
        pop(seqIf.stallCount);
        pop({15'd0, seqIf.mdTimeout});
        @(negedge clk);
        rst = 1'b1;
        expStall = 0;
        @(negedge clk);

        // Bypass selection
        seqIf.decRs1 = 5'd5; seqIf.decRs1Used = 1'b1;
        seqIf.exRd = 5'd5; seqIf.exWrEn = 1'b1;
        seqIf.memRd = 5'd5; seqIf.memWrEn = 1'b1;
        checkBypass("byp-ex", 2'd1, 2'd0);
        seqIf.exRd = 5'd0;
        checkBypass("byp-mem", 2'd2, 2'd0);
        seqIf.decRs1 = 5'd0; seqIf.memRd = 5'd0;
        checkBypass("byp-zero", 2'd0, 2'd0);
        seqIf.decRs2 = 5'd9; seqIf.decRs2Used = 1'b1;
        seqIf.exRd = 5'd9; seqIf.exWrEn = 1'b0;
        seqIf.memRd = 5'd9; seqIf.memWrEn = 1'b1;
        checkBypass("byp-op2mem", 2'd0, 2'd2);
        seqIf.exWrEn = 1'b1;
        checkBypass("byp-op2ex", 2'd0, 2'd1);
        seqIf.decRs2Used = 1'b0;
        checkBypass("byp-unused", 2'd0, 2'd0);
        @(negedge clk);
        clearInputs();

        // Load-use hazard: one stalled cycle
        seqIf.exIsLoad = 1'b1; seqIf.exWrEn = 1'b1; seqIf.exRd = 5'd7;
        seqIf.decRs2 = 5'd7; seqIf.decRs2Used = 1'b1;
        cycle("lu", C_STALL);
        clearInputs();
        cycle("lu-after", C_IDLE);
        // Load to r0 never stalls
        seqIf.exIsLoad = 1'b1; seqIf.exWrEn = 1'b1; seqIf.exRd = 5'd0;
        seqIf.decRs1 = 5'd0; seqIf.decRs1Used = 1'b1;
        cycle("lu-r0", C_IDLE);
        clearInputs();

        // Mul/div with mdDone after 4 waiting cycles
        seqIf.decValid = 1'b1; seqIf.decIsMulDiv = 1'b1;
        cycle("md-issue", C_START);
        clearInputs();
        for (int i = 0; i < 4; i++) cycle("md-wait", C_STALL);
        seqIf.mdDone = 1'b1;
        cycle("md-done", C_IDLE);
        clearInputs();
        cycle("md-run", C_IDLE);

        // Mul/div timeout
        seqIf.decValid = 1'b1; seqIf.decIsMulDiv = 1'b1;
        cycle("to-issue", C_START);
        clearInputs();
        for (int i = 0; i < 63; i++) cycle("to-wait", C_STALL);
        push("to-pre", 16'd0);
        #1;
        pop({15'd0, seqIf.mdTimeout});
        cycle("to-abort", C_TOUT);
        push("to-sticky", 16'd1);
        #1;
        pop({15'd0, seqIf.mdTimeout});
        cycle("to-run", C_IDLE);

        // Mispredict in RUN beats load-use and mul/div issue
        seqIf.exBrMiss = 1'b1; seqIf.decValid = 1'b1; seqIf.decIsMulDiv = 1'b1;
        seqIf.exIsLoad = 1'b1; seqIf.exWrEn = 1'b1; seqIf.exRd = 5'd3;
        seqIf.decRs1 = 5'd3; seqIf.decRs1Used = 1'b1;
        push("br-copy", 16'd1);
        #1;
        pop({15'd0, seqIf.isBranchPredictMiss});
        cycle("br-run", C_BR);
        clearInputs();
        push("br-copy0", 16'd0);
        #1;
        pop({15'd0, seqIf.isBranchPredictMiss});
        cycle("br-stay", C_IDLE);

        // Mispredict coincident with mdDone in MD_WAIT
        seqIf.decValid = 1'b1; seqIf.decIsMulDiv = 1'b1;
        cycle("brmd-issue", C_START);
        clearInputs();
        cycle("brmd-wait", C_STALL);
        cycle("brmd-wait", C_STALL);
        seqIf.exBrMiss = 1'b1; seqIf.mdDone = 1'b1;
        cycle("brmd-abort", C_BRAB);
        clearInputs();
        push("brmd-tout", 16'd1);
        #1;
        pop({15'd0, seqIf.mdTimeout});
        cycle("brmd-run", C_IDLE);

        // Long held load-use stall saturates the counter
        seqIf.exIsLoad = 1'b1; seqIf.exWrEn = 1'b1; seqIf.exRd = 5'd12;
        seqIf.decRs1 = 5'd12; seqIf.decRs1Used = 1'b1;
        for (int i = 0; i < 70000; i++) begin
            expStall = satNext(expStall);
            @(negedge clk);
        end
        cycle("sat", C_STALL);
        cycle("sat", C_STALL);
        clearInputs();
        cycle("sat-end", C_IDLE);

        // Asynchronous reset in the middle of MD_WAIT
        seqIf.decValid = 1'b1; seqIf.decIsMulDiv = 1'b1;
        cycle("ar-issue", C_START);
        clearInputs();
        cycle("ar-wait", C_STALL);
        #2;
        rst = 1'b0;
        expStall = 0;
        push("ar-ctrl", 16'd0);
        push("ar-cnt", 16'd0);
        push("ar-tout", 16'd0);
        #1;
        pop(ctrlObs());
        pop(seqIf.stallCount);
        pop({15'd0, seqIf.mdTimeout});
        @(negedge clk);
        push("ar-held", 16'd0);
        #1;
        pop(ctrlObs());
        @(negedge clk);
        rst = 1'b1;
        cycle("ar-run", C_IDLE);
        cycle("ar-run", C_IDLE);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pipeline_sequencer.md
PIPELINE_SEQUENCER -- requirements
Module: pipeline_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have inputs decRs1 and decRs2, 5 bits each: decode-stage source register indices.
REQ-004 SHALL have inputs decRs1Used, decRs2Used, decValid, decIsMulDiv, 1 bit each: decode-stage operand use, valid instruction, multi-cycle mul/div op.
REQ-005 SHALL have inputs exRd (5), exWrEn (1), exIsLoad (1): execute-stage destination, write enable, load flag.
REQ-006 SHALL have inputs memRd (5), memWrEn (1): memory-stage destination and write enable.
REQ-007 SHALL have inputs exBrMiss (1): branch mispredict resolved in execute; mdDone (1): mul/div result ready.
REQ-008 SHALL have outputs op1BypassCtrl, op2BypassCtrl, 2 bits each: 0 = register file, 1 = EX/MEM result, 2 = MEM/WB result; 3 unused.
REQ-009 SHALL have outputs stallFetch, stallDecode, flushExecute, flushDecode, isBranchPredictMiss, mdStart, mdAbort, mdTimeout, 1 bit each.
REQ-010 SHALL have output stallCount, 16 bits: saturating count of stalled cycles.

Function
REQ-011 Bypass: opNBypassCtrl SHALL be 1 when rsNUsed, exWrEn, exRd != 0 and exRd == rsN; else 2 when memWrEn, memRd != 0 and memRd == rsN; else 0 (combinational, EX wins over MEM).
REQ-012 Load-use hazard: in state RUN, exIsLoad & exWrEn & exRd != 0 matching a used decode source SHALL assert stallFetch, stallDecode, flushExecute for that cycle only; no state change.
REQ-013 FSM states: RUN, MD_WAIT; reset state RUN.
REQ-014 RUN -> MD_WAIT when decValid & decIsMulDiv, no load-use hazard, no exBrMiss; mdStart SHALL pulse high exactly that cycle.
REQ-015 In MD_WAIT: stallFetch = stallDecode = flushExecute = 1 every cycle; mdStart = 0.
REQ-016 MD_WAIT -> RUN on the cycle mdDone = 1; stalls deasserted that same cycle so the instruction advances.
REQ-017 Wait counter: 6-bit, cleared on entry to MD_WAIT, +1 per MD_WAIT cycle; when it reaches 63 without mdDone, SHALL pulse mdAbort, set sticky mdTimeout, return to RUN.
REQ-018 exBrMiss SHALL have top priority in any state: same cycle flushDecode = flushExecute = 1, isBranchPredictMiss = 1, stallFetch = stallDecode = 0, load-use stall suppressed, mdStart suppressed.
REQ-019 exBrMiss in MD_WAIT SHALL pulse mdAbort that cycle and return to RUN; mdTimeout unaffected.
REQ-020 exBrMiss coincident with mdDone in MD_WAIT: mdDone ignored, mdAbort pulses, next state RUN.
REQ-021 stallCount SHALL increment by 1 on each cycle stallDecode = 1, saturate at 0xFFFF, never wrap.
REQ-022 isBranchPredictMiss SHALL be combinational copy of exBrMiss; all other outputs except stallCount, mdTimeout derived from current state and inputs.

Reset
REQ-023 rst low SHALL immediately force state RUN, wait counter 0, stallCount 0, mdTimeout 0, independent of clk.
REQ-024 While rst low, all stall, flush, mdStart, mdAbort outputs SHALL be 0; bypass outputs remain combinational.
REQ-025 Reset asserted during MD_WAIT SHALL NOT pulse mdAbort; state returns to RUN.

Verification
REQ-026 decRs1=5, used; exRd=5, exWrEn=1; memRd=5, memWrEn=1 -> op1BypassCtrl=1; exRd=0 instead -> 2; rs=0 everywhere -> 0.
REQ-027 exIsLoad=1, exRd=7, decRs2=7 used -> one cycle stallFetch=stallDecode=flushExecute=1, stallCount 0->1.
REQ-028 decIsMulDiv issue, mdDone after 4 cycles -> mdStart one pulse, stalls high 4 cycles, low on mdDone cycle, stallCount=4.
REQ-029 MD_WAIT with no mdDone -> after 63 cycles mdAbort pulse, mdTimeout=1, state RUN.
REQ-030 exBrMiss with mdDone in MD_WAIT -> flushDecode=flushExecute=1, mdAbort=1, stalls 0, next cycle RUN.
REQ-031 Hold stall 70000 cycles -> stallCount stays 0xFFFF; async rst mid-MD_WAIT -> outputs 0, no mdAbort.
